// File: rtl/bus_responder_6502.sv
// Purpose : 6502 external-bus responder: decodes extAB/RW into fast memory, a
//           slow memory region that stalls reads via RDY, and a 16-bit
//           interval timer register page that drives IRQ_L.
// Latency : fast-memory and register reads are combinational in the same
//           cycle; slow reads take WAIT_STATES+1 cycles; writes land on the
//           phi2 edge that ends the cycle.
// Backpressure: RDY low stalls slow-region reads only; writes never stall.
// Ports   : phi2/RES_L clock and async active-low reset; extAB/RW/db_in from
//           the CPU; db_out/db_oe/RDY/IRQ_L back to the CPU; mem_addr/
//           mem_wdata/mem_we/mem_rdata to external memory.
module bus_responder_6502 #(
  parameter logic [7:0]  REG_PAGE    = 8'hD0,
  parameter logic [7:0]  SLOW_LO     = 8'h80,
  parameter logic [7:0]  SLOW_HI     = 8'hBF,
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic        phi2,
  input  logic        RES_L,
  input  logic [15:0] extAB,
  input  logic        RW,
  input  logic [7:0]  db_in,
  output logic [7:0]  db_out,
  output logic        db_oe,
  output logic        RDY,
  output logic        IRQ_L,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        mem_we,
  input  logic [7:0]  mem_rdata
);

  typedef enum logic {ST_IDLE, ST_WAIT} state_t;

  // Counter preload for the WAIT state; unused when WAIT_STATES is 0.
  localparam logic [3:0] WS_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  // ---------------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------------
  logic       reg_sel;
  logic       slow_sel;
  logic [2:0] reg_off;

  assign reg_sel  = (extAB[15:8] == REG_PAGE);
  assign slow_sel = !reg_sel && (extAB[15:8] >= SLOW_LO) && (extAB[15:8] <= SLOW_HI);
  assign reg_off  = extAB[2:0];

  // ---------------------------------------------------------------------------
  // Memory path
  // ---------------------------------------------------------------------------
  logic [7:0] reg_rdata;

  assign mem_addr  = extAB;
  assign mem_wdata = db_in;
  assign mem_we    = !RW && !reg_sel && RES_L;
  assign db_oe     = RW && RES_L;
  assign db_out    = reg_sel ? reg_rdata : mem_rdata;

  // ---------------------------------------------------------------------------
  // Wait-state FSM
  // ---------------------------------------------------------------------------
  state_t     state_q, state_d;
  logic [3:0] wcnt_q, wcnt_d;
  logic       rdy_fsm;

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    rdy_fsm = 1'b1;
    case (state_q)
      ST_IDLE: begin
        if (RW && slow_sel && (WAIT_STATES > 0)) begin
          rdy_fsm = 1'b0;
          wcnt_d  = WS_LOAD;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (RW && slow_sel) begin
          if (wcnt_q != 4'd0) begin
            rdy_fsm = 1'b0;
            wcnt_d  = wcnt_q - 4'd1;
          end else begin
            // Final cycle of the stalled read: CPU takes the data now.
            state_d = ST_IDLE;
          end
        end else begin
          // CPU moved away or turned the cycle into a write: abandon the wait.
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Reset must release a stalled CPU without waiting for a clock edge.
  assign RDY = rdy_fsm | ~RES_L;

  // ---------------------------------------------------------------------------
  // Timer registers
  // ---------------------------------------------------------------------------
  logic [7:0]  tlo_q, tlo_d;
  logic [7:0]  thi_q, thi_d;
  logic [15:0] cnt_q, cnt_d;
  logic [7:0]  hold_q, hold_d;
  logic        en_q, en_d;
  logic        ie_q, ie_d;
  logic        os_q, os_d;
  logic        tf_q, tf_d;

  logic reg_wr, reg_rd, underflow;
  logic wr_tlo, wr_thi, wr_ctrl, wr_stat, rd_cntlo;

  assign reg_wr    = reg_sel && !RW;
  assign reg_rd    = reg_sel && RW;
  assign wr_tlo    = reg_wr && (reg_off == 3'd0);
  assign wr_thi    = reg_wr && (reg_off == 3'd1);
  assign wr_ctrl   = reg_wr && (reg_off == 3'd2);
  assign wr_stat   = reg_wr && (reg_off == 3'd3);
  assign rd_cntlo  = reg_rd && (reg_off == 3'd4);
  assign underflow = en_q && (cnt_q == 16'd0);

  always_comb begin
    tlo_d  = wr_tlo ? db_in : tlo_q;
    thi_d  = wr_thi ? db_in : thi_q;
    hold_d = rd_cntlo ? cnt_q[15:8] : hold_q;

    // A THI write restarts the count even on an underflow edge.
    cnt_d = cnt_q;
    if (wr_thi) begin
      cnt_d = {db_in, tlo_q};
    end else if (underflow) begin
      cnt_d = {thi_q, tlo_q};
    end else if (en_q) begin
      cnt_d = cnt_q - 16'd1;
    end

    // A fresh underflow beats a simultaneous write-one-to-clear.
    tf_d = tf_q;
    if (underflow) begin
      tf_d = 1'b1;
    end else if (wr_stat && db_in[0]) begin
      tf_d = 1'b0;
    end

    // Software's CTRL write beats the one-shot auto-disable.
    en_d = en_q;
    ie_d = ie_q;
    os_d = os_q;
    if (wr_ctrl) begin
      en_d = db_in[0];
      ie_d = db_in[1];
      os_d = db_in[2];
    end else if (underflow && os_q) begin
      en_d = 1'b0;
    end
  end

  always_comb begin
    reg_rdata = 8'h00;
    case (reg_off)
      3'd0:    reg_rdata = tlo_q;
      3'd1:    reg_rdata = thi_q;
      3'd2:    reg_rdata = {5'd0, os_q, ie_q, en_q};
      3'd3:    reg_rdata = {en_q, 6'd0, tf_q};
      3'd4:    reg_rdata = cnt_q[7:0];
      3'd5:    reg_rdata = hold_q;
      default: reg_rdata = 8'h00;
    endcase
  end

  assign IRQ_L = ~(tf_q & ie_q);

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge phi2 or negedge RES_L) begin
    if (!RES_L) begin
      state_q <= ST_IDLE;
      wcnt_q  <= 4'd0;
      tlo_q   <= 8'hFF;
      thi_q   <= 8'hFF;
      cnt_q   <= 16'hFFFF;
      hold_q  <= 8'h00;
      en_q    <= 1'b0;
      ie_q    <= 1'b0;
      os_q    <= 1'b0;
      tf_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      tlo_q   <= tlo_d;
      thi_q   <= thi_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
      en_q    <= en_d;
      ie_q    <= ie_d;
      os_q    <= os_d;
      tf_q    <= tf_d;
    end
  end

endmodule

// File: tb/tb_bus_responder_6502.sv
module tb_bus_responder_6502;

  logic        phi2;
  logic        RES_L;
  logic [15:0] extAB;
  logic        RW;
  logic [7:0]  db_in;
  logic [7:0]  db_out;
  logic        db_oe;
  logic        RDY;
  logic        IRQ_L;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_we;
  logic [7:0]  mem_rdata;

  int checks = 0;
  int errors = 0;

  bus_responder_6502 #(
    .REG_PAGE   (8'hD0),
    .SLOW_LO    (8'h80),
    .SLOW_HI    (8'hBF),
    .WAIT_STATES(2)
  ) dut (
    .phi2     (phi2),
    .RES_L    (RES_L),
    .extAB    (extAB),
    .RW       (RW),
    .db_in    (db_in),
    .db_out   (db_out),
    .db_oe    (db_oe),
    .RDY      (RDY),
    .IRQ_L    (IRQ_L),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_we   (mem_we),
    .mem_rdata(mem_rdata)
  );

  initial phi2 = 1'b0;
  always #5 phi2 = ~phi2;

  typedef struct {
    logic [15:0] a;
    logic        rw;
    logic [7:0]  wd;
    logic [7:0]  rd;
    logic [7:0]  e_db;
    logic        e_rdy;
    logic        e_we;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(input logic [15:0] a, input logic rw, input logic [7:0] wd,
                              input logic [7:0] rd, input logic [7:0] e_db,
                              input logic e_rdy, input logic e_we);
    vec_t v;
    v.a = a; v.rw = rw; v.wd = wd; v.rd = rd;
    v.e_db = e_db; v.e_rdy = e_rdy; v.e_we = e_we;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Present one bus cycle; outputs are stable 1 time unit after the negedge,
  // well before the posedge that ends the cycle.
  task automatic bus(input logic [15:0] a, input logic rw, input logic [7:0] wd,
                     input logic [7:0] rd);
    @(negedge phi2);
    extAB = a; RW = rw; db_in = wd; mem_rdata = rd;
    #1;
  endtask

  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    bus(a, 1'b0, d, 8'h00);
  endtask

  task automatic idle();
    bus(16'h0000, 1'b1, 8'h00, 8'h00);
  endtask

  task automatic rd_chk(input string nm, input logic [15:0] a, input logic [7:0] exp);
    bus(a, 1'b1, 8'h00, 8'hEE);
    chk(nm, {8'h00, db_out}, {8'h00, exp});
  endtask

  initial begin
    // Reset / decode / wait-state table (timer disabled throughout).
    vt.push_back(mk(16'h0000, 1, 8'h00, 8'h5A, 8'h5A, 1, 0));
    vt.push_back(mk(16'h9000, 1, 8'h00, 8'h77, 8'h77, 0, 0));
    vt.push_back(mk(16'h9000, 1, 8'h00, 8'h77, 8'h77, 0, 0));
    vt.push_back(mk(16'h9000, 1, 8'h00, 8'h77, 8'h77, 1, 0));
    vt.push_back(mk(16'h9000, 0, 8'h33, 8'h00, 8'h00, 1, 1));
    vt.push_back(mk(16'h0010, 1, 8'h00, 8'h11, 8'h11, 1, 0));
    vt.push_back(mk(16'h9000, 1, 8'h00, 8'h44, 8'h44, 0, 0));
    vt.push_back(mk(16'h1000, 1, 8'h00, 8'h22, 8'h22, 1, 0));
    vt.push_back(mk(16'h1000, 1, 8'h00, 8'h23, 8'h23, 1, 0));
    vt.push_back(mk(16'hBF00, 1, 8'h00, 8'h66, 8'h66, 0, 0));
    vt.push_back(mk(16'hBF00, 1, 8'h00, 8'h66, 8'h66, 0, 0));
    vt.push_back(mk(16'hBF00, 1, 8'h00, 8'h66, 8'h66, 1, 0));
    vt.push_back(mk(16'hC000, 1, 8'h00, 8'h01, 8'h01, 1, 0));
    vt.push_back(mk(16'h7FFF, 1, 8'h00, 8'h02, 8'h02, 1, 0));
    vt.push_back(mk(16'h8000, 1, 8'h00, 8'h03, 8'h03, 0, 0));
    vt.push_back(mk(16'h8000, 0, 8'hA5, 8'h00, 8'h00, 1, 1));
    vt.push_back(mk(16'h8000, 0, 8'hA6, 8'h00, 8'h00, 1, 1));
    vt.push_back(mk(16'hD000, 1, 8'h00, 8'h00, 8'hFF, 1, 0));
    vt.push_back(mk(16'hD001, 1, 8'h00, 8'h00, 8'hFF, 1, 0));
    vt.push_back(mk(16'hD002, 1, 8'h00, 8'h00, 8'h00, 1, 0));
    vt.push_back(mk(16'hD003, 1, 8'h00, 8'h00, 8'h00, 1, 0));
    vt.push_back(mk(16'hD005, 1, 8'h00, 8'h00, 8'h00, 1, 0));
    vt.push_back(mk(16'hD004, 1, 8'h00, 8'h00, 8'hFF, 1, 0));
    vt.push_back(mk(16'hD005, 1, 8'h00, 8'h00, 8'hFF, 1, 0));
    vt.push_back(mk(16'hD006, 0, 8'h55, 8'h00, 8'h00, 1, 0));
    vt.push_back(mk(16'hD006, 1, 8'h00, 8'h00, 8'h00, 1, 0));
    vt.push_back(mk(16'hD007, 1, 8'h00, 8'h00, 8'h00, 1, 0));

    // Reset state, with a slow read and then a write presented during reset.
    RES_L = 1'b0; extAB = 16'h9000; RW = 1'b1; db_in = 8'h00; mem_rdata = 8'h00;
    #12;
    chk("rst_rdy", {15'd0, RDY}, 16'd1);
    chk("rst_irq", {15'd0, IRQ_L}, 16'd1);
    chk("rst_oe", {15'd0, db_oe}, 16'd0);
    RW = 1'b0;
    #1;
    chk("rst_we", {15'd0, mem_we}, 16'd0);
    @(negedge phi2);
    RES_L = 1'b1;

    for (int i = 0; i < vt.size(); i++) begin
      bus(vt[i].a, vt[i].rw, vt[i].wd, vt[i].rd);
      chk($sformatf("v%0d_rdy", i), {15'd0, RDY}, {15'd0, vt[i].e_rdy});
      chk($sformatf("v%0d_we", i), {15'd0, mem_we}, {15'd0, vt[i].e_we});
      chk($sformatf("v%0d_oe", i), {15'd0, db_oe}, {15'd0, vt[i].rw});
      chk($sformatf("v%0d_irq", i), {15'd0, IRQ_L}, 16'd1);
      chk($sformatf("v%0d_addr", i), mem_addr, vt[i].a);
      if (vt[i].rw)
        chk($sformatf("v%0d_db", i), {8'h00, db_out}, {8'h00, vt[i].e_db});
      else
        chk($sformatf("v%0d_wdata", i), {8'h00, mem_wdata}, {8'h00, vt[i].wd});
    end

    // Periodic timer: EN+IE first, then reload 3 via TLO/THI.
    wr(16'hD002, 8'h03);
    wr(16'hD000, 8'h03);
    wr(16'hD001, 8'h00);
    for (int i = 1; i <= 5; i++) begin
      idle();
      chk($sformatf("per_irq_%0d", i), {15'd0, IRQ_L}, (i == 5) ? 16'd0 : 16'd1);
    end
    rd_chk("per_stat_set", 16'hD003, 8'h81);
    wr(16'hD003, 8'h01);
    rd_chk("per_stat_clr", 16'hD003, 8'h80);
    chk("per_irq_clr", {15'd0, IRQ_L}, 16'd1);
    wr(16'hD002, 8'h00);

    // One-shot with reload 1.
    wr(16'hD003, 8'h01);
    wr(16'hD000, 8'h01);
    wr(16'hD001, 8'h00);
    wr(16'hD002, 8'h07);
    idle();
    idle();
    rd_chk("os_stat", 16'hD003, 8'h01);
    chk("os_irq", {15'd0, IRQ_L}, 16'd0);
    rd_chk("os_ctrl", 16'hD002, 8'h06);
    wr(16'hD003, 8'h01);
    for (int i = 0; i < 3; i++) rd_chk($sformatf("os_quiet_%0d", i), 16'hD003, 8'h00);

    // W1C on the same edge as an underflow: the set wins.
    wr(16'hD002, 8'h07);
    idle();
    wr(16'hD003, 8'h01);
    rd_chk("w1c_vs_uf", 16'hD003, 8'h01);

    // CTRL write on the same edge as the one-shot auto-clear: the write wins.
    wr(16'hD002, 8'h07);
    idle();
    wr(16'hD002, 8'h07);
    rd_chk("ctrl_vs_os", 16'hD002, 8'h07);
    wr(16'hD002, 8'h00);
    wr(16'hD003, 8'h01);

    // Count snapshot: CNTLO latches the high byte into hold.
    wr(16'hD000, 8'h34);
    wr(16'hD001, 8'h12);
    rd_chk("cntlo_1234", 16'hD004, 8'h34);
    wr(16'hD002, 8'h01);
    for (int i = 0; i < 60; i++) idle();
    rd_chk("cnthi_held", 16'hD005, 8'h12);
    rd_chk("cntlo_run", 16'hD004, 8'hF7);
    rd_chk("cnthi_new", 16'hD005, 8'h11);

    // Reload 0: TF sets on every edge; IE off keeps IRQ_L high.
    wr(16'hD002, 8'h00);
    wr(16'hD003, 8'h01);
    wr(16'hD000, 8'h00);
    wr(16'hD001, 8'h00);
    wr(16'hD002, 8'h01);
    idle();
    rd_chk("z_stat", 16'hD003, 8'h81);
    wr(16'hD003, 8'h01);
    rd_chk("z_stat_again", 16'hD003, 8'h81);
    chk("z_irq_masked", {15'd0, IRQ_L}, 16'd1);

    // Reset asserted in the middle of a stalled read.
    bus(16'h9000, 1'b1, 8'h00, 8'h00);
    chk("mw_rdy0", {15'd0, RDY}, 16'd0);
    bus(16'h9000, 1'b1, 8'h00, 8'h00);
    chk("mw_rdy1", {15'd0, RDY}, 16'd0);
    #1;
    RES_L = 1'b0;
    #1;
    chk("mw_rst_rdy", {15'd0, RDY}, 16'd1);
    chk("mw_rst_oe", {15'd0, db_oe}, 16'd0);
    @(negedge phi2);
    RES_L = 1'b1;
    rd_chk("post_rst_stat", 16'hD003, 8'h00);
    rd_chk("post_rst_tlo", 16'hD000, 8'hFF);
    rd_chk("post_rst_ctrl", 16'hD002, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
